// File: rtl/divsqrt_issue_ctrl.sv
// divsqrt_issue_ctrl: issue/retire control for a fixed-latency div/sqrt datapath.
// Credits bound inflight + queued results so the stall-free datapath never overruns the FIFO.
package fpall_pkg;
    typedef enum logic [1:0] {OP_DIV = 2'd0, OP_SQRT = 2'd1} fp_op_e;
    typedef enum logic [1:0] {FMT_FP32 = 2'd0, FMT_FP16 = 2'd1, FMT_BF16 = 2'd2, FMT_FP8 = 2'd3} fp_fmt_e;
endpackage

module divsqrt_issue_ctrl
    import fpall_pkg::*;
#(
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  fp_op_e           in_opcode,
    input  fp_fmt_e          in_fmt,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_y,
    input  logic [TAG_W-1:0] in_tag,
    output fp_op_e           dp_opcode,
    output fp_fmt_e          dp_fmt,
    output logic [31:0]      dp_x,
    output logic [31:0]      dp_y,
    input  logic [31:0]      dp_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_r,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [CW-1:0]      credits_q, credits_d, count_q, count_d;
    logic [PW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [TAG_W-1:0]   tag_q [LATENCY];
    logic [TAG_W-1:0]   tag_d [LATENCY];
    logic [31:0]        r_mem [FIFO_DEPTH];
    logic [TAG_W-1:0]   t_mem [FIFO_DEPTH];
    fp_op_e             dp_opcode_q;
    fp_fmt_e            dp_fmt_q;
    logic [31:0]        dp_x_q, dp_y_q;
    logic               fire, pop, push;

    assign in_ready  = rst_n & (credits_q != '0);
    assign fire      = in_valid & in_ready;
    assign out_valid = count_q != '0;
    assign pop       = out_valid & out_ready;
    assign push      = vld_q[LATENCY-1];
    assign out_r     = r_mem[rptr_q];
    assign out_tag   = t_mem[rptr_q];
    assign busy      = (|vld_q) | out_valid;
    assign dp_opcode = dp_opcode_q;
    assign dp_fmt    = dp_fmt_q;
    assign dp_x      = dp_x_q;
    assign dp_y      = dp_y_q;

    always_comb begin
        credits_d = (fire & ~pop) ? credits_q - CW'(1) : (pop & ~fire) ? credits_q + CW'(1) : credits_q;
        count_d   = (push & ~pop) ? count_q + CW'(1) : (pop & ~push) ? count_q - CW'(1) : count_q;
        wptr_d    = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d    = pop ? rptr_q + PW'(1) : rptr_q;
        vld_d     = '0;
        tag_d     = '{default: '0};
        vld_d[0]  = fire;
        tag_d[0]  = in_tag;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credits_q   <= CW'(FIFO_DEPTH);
            count_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            vld_q       <= '0;
            dp_opcode_q <= OP_DIV;
            dp_fmt_q    <= FMT_FP32;
            dp_x_q      <= '0;
            dp_y_q      <= '0;
        end else begin
            credits_q <= credits_d;
            count_q   <= count_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            vld_q     <= vld_d;
            // operands only move on an accepted request to keep datapath inputs quiet
            if (fire) begin
                dp_opcode_q <= in_opcode;
                dp_fmt_q    <= in_fmt;
                dp_x_q      <= in_x;
                dp_y_q      <= in_y;
            end
        end
    end

    // dp_r is only sampled when a tracked op emerges, so idle X never reaches the FIFO
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        if (push) begin
            r_mem[wptr_q] <= dp_r;
            t_mem[wptr_q] <= tag_q[LATENCY-1];
        end
    end
endmodule

// File: tb/tb_divsqrt_issue_ctrl.sv
// tb_divsqrt_issue_ctrl: scoreboard bench with a stub datapath of matching latency.
module tb_divsqrt_issue_ctrl;
    import fpall_pkg::*;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 4;
    localparam int TW      = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
    fp_op_e in_opcode = OP_DIV, dp_opcode;
    fp_fmt_e in_fmt = FMT_FP32, dp_fmt;
    logic [31:0] in_x = '0, in_y = '0, dp_x, dp_y, dp_r, out_r;
    logic [TW-1:0] in_tag = '0, out_tag;

    typedef struct {
        logic [31:0]   r;
        logic [TW-1:0] t;
    } exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0, fires = 0, pops = 0;

    always #5 clk = ~clk;

    divsqrt_issue_ctrl #(.LATENCY(LATENCY), .FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_fmt(in_fmt), .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
        .dp_opcode(dp_opcode), .dp_fmt(dp_fmt), .dp_x(dp_x), .dp_y(dp_y), .dp_r(dp_r),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_tag(out_tag), .busy(busy)
    );

    function automatic logic [31:0] dp_model(fp_op_e op, logic [31:0] x, logic [31:0] y);
        if (op == OP_SQRT) return (x == 32'h40800000) ? 32'h40000000 : x ^ 32'hA5A50000;
        return (x == 32'h40C00000 && y == 32'h40000000) ? 32'h40400000 : x + y;
    endfunction

    // Stub datapath: one register after combinational dp_* gives LATENCY=2.
    logic [31:0] dp_pipe;
    always @(posedge clk) dp_pipe <= dp_model(dp_opcode, dp_x, dp_y);
    assign dp_r = dp_pipe;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) sb.delete();
        else begin
            if (out_valid && out_ready) begin
                pops++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got r=%h tag=%0d, required none", out_r, out_tag);
                end else begin
                    e = sb.pop_front();
                    if (out_r !== e.r || out_tag !== e.t) begin
                        errors++;
                        $display("FAIL result_order: got r=%h tag=%0d, required r=%h tag=%0d", out_r, out_tag, e.r, e.t);
                    end
                end
            end
            if (in_valid && in_ready) begin
                fires++;
                sb.push_back('{dp_model(in_opcode, in_x, in_y), in_tag});
            end
        end
        if (int'(dut.credits_q) + $countones(dut.vld_q) + int'(dut.count_q) != DEPTH) begin
            errors++;
            $display("FAIL credit_invariant: got %0d, required %0d",
                     int'(dut.credits_q) + $countones(dut.vld_q) + int'(dut.count_q), DEPTH);
        end
        if (dut.vld_q[LATENCY-1] && int'(dut.count_q) == DEPTH) begin
            errors++;
            $display("FAIL fifo_overflow: got push with count %0d, required count < %0d", dut.count_q, DEPTH);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input fp_op_e op, input logic [31:0] x, input logic [31:0] y, input logic [TW-1:0] t);
        in_valid  = 1'b1;
        in_opcode = op;
        in_fmt    = FMT_FP32;
        in_x      = x;
        in_y      = y;
        in_tag    = t;
    endtask

    task automatic drain();
        int w = 0;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        while (busy && w < 40) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout: got busy=%b, required 0", busy);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks += 4;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (dp_x !== 32'h0) begin errors++; $display("FAIL reset_dp_x: got %h, required 0", dp_x); end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_single();
        int lat = 1;
        tick();
        out_ready = 1'b0;
        drive(OP_SQRT, 32'h40800000, 32'h0, 4'd3);
        @(negedge clk);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checks += 4;
        if (lat != LATENCY + 1) begin errors++; $display("FAIL single_latency: got %0d, required %0d", lat, LATENCY + 1); end
        if (out_r !== 32'h40000000) begin errors++; $display("FAIL single_r: got %h, required 40000000", out_r); end
        if (out_tag !== 4'd3) begin errors++; $display("FAIL single_tag: got %0d, required 3", out_tag); end
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b, required 1", busy); end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after_pop: got %b, required 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ov = '0;
        logic [15:0] ov_exp = 16'h00FF << (LATENCY + 1);
        int p0 = pops;
        for (int k = 0; k < 16; k++) begin
            tick();
            out_ready = 1'b1;
            if (k < 8) drive(OP_DIV, 32'h40C00000, 32'h40000000, 4'(k));
            else in_valid = 1'b0;
            @(negedge clk);
            ov[k] = out_valid;
            if (k < 8) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b at op %0d, required 1", in_ready, k); end
            end
            if (out_valid) begin
                checks++;
                if (out_r !== 32'h40400000) begin errors++; $display("FAIL b2b_result: got %h, required 40400000", out_r); end
            end
        end
        checks += 2;
        if (ov !== ov_exp) begin errors++; $display("FAIL b2b_rate: got %h, required %h", ov, ov_exp); end
        if (pops - p0 != 8) begin errors++; $display("FAIL b2b_pops: got %0d, required 8", pops - p0); end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_credits();
        int f0 = fires, p0 = pops;
        for (int k = 0; k < 8; k++) begin
            tick();
            out_ready = 1'b0;
            drive(OP_DIV, 32'h100 + k, 32'h2, 4'(k));
            @(negedge clk);
        end
        checks += 2;
        if (fires - f0 != DEPTH) begin errors++; $display("FAIL credit_fires: got %0d, required %0d", fires - f0, DEPTH); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL credit_stall: got %b, required 0", in_ready); end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        tick();
        out_ready = 1'b0;
        repeat (4) begin
            tick();
            @(negedge clk);
        end
        checks += 3;
        if (fires - f0 != DEPTH + 1) begin errors++; $display("FAIL credit_refire: got %0d, required %0d", fires - f0, DEPTH + 1); end
        if (pops - p0 != 1) begin errors++; $display("FAIL credit_one_pop: got %0d, required 1", pops - p0); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL credit_restall: got %b, required 0", in_ready); end
        drain();
    endtask

    task automatic test_pingpong();
        int n = 0, cyc = 0, p0 = pops;
        while (n < 32 && cyc < 300) begin
            tick();
            drive(OP_DIV, 32'h2000 + n, 32'(n), 4'(n));
            out_ready = cyc[0];
            @(negedge clk);
            if (in_ready) n++;
            cyc++;
        end
        drain();
        checks += 3;
        if (n != 32) begin errors++; $display("FAIL pingpong_issued: got %0d, required 32", n); end
        if (pops - p0 != 32) begin errors++; $display("FAIL pingpong_pops: got %0d, required 32", pops - p0); end
        if (sb.size() != 0) begin errors++; $display("FAIL pingpong_left: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        int lat = 1;
        int p0;
        for (int k = 0; k < 3; k++) begin
            tick();
            out_ready = 1'b0;
            drive(OP_DIV, 32'h3000 + k, 32'h1, 4'(10 + k));
            @(negedge clk);
        end
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks += 2;
        if (dut.count_q !== 3'd1) begin errors++; $display("FAIL mid_pre_count: got %0d, required 1", dut.count_q); end
        if ($countones(dut.vld_q) != 2) begin errors++; $display("FAIL mid_pre_inflight: got %0d, required 2", $countones(dut.vld_q)); end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b, required 0", out_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b, required 0", busy); end
        if (dut.credits_q !== 3'd4) begin errors++; $display("FAIL mid_credits: got %0d, required 4", dut.credits_q); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b, required 1", in_ready); end
        p0 = pops;
        out_ready = 1'b1;
        repeat (5) begin
            tick();
            @(negedge clk);
        end
        checks++;
        if (pops != p0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_output: got %0d pops, required 0", pops - p0); end
        tick();
        out_ready = 1'b0;
        drive(OP_SQRT, 32'h40800000, 32'h0, 4'd5);
        @(negedge clk);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checks += 3;
        if (lat != LATENCY + 1) begin errors++; $display("FAIL mid_fresh_latency: got %0d, required %0d", lat, LATENCY + 1); end
        if (out_r !== 32'h40000000) begin errors++; $display("FAIL mid_fresh_r: got %h, required 40000000", out_r); end
        if (out_tag !== 4'd5) begin errors++; $display("FAIL mid_fresh_tag: got %0d, required 5", out_tag); end
        drain();
    endtask

    task automatic test_hold();
        int w = 0;
        tick();
        out_ready = 1'b0;
        drive(OP_SQRT, 32'h40800000, 32'h0, 4'd6);
        @(negedge clk);
        tick();
        drive(OP_DIV, 32'h40C00000, 32'h40000000, 4'd7);
        @(negedge clk);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        while (!out_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_r !== 32'h40000000 || out_tag !== 4'd6) begin
                errors++;
                $display("FAIL hold_stable: got v=%b r=%h tag=%0d at cycle %0d, required v=1 r=40000000 tag=6", out_valid, out_r, out_tag, k);
            end
            tick();
            @(negedge clk);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_credits();
        test_pingpong();
        test_reset_mid();
        test_hold();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL final_scoreboard: got %0d pending, required 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
